// File: rtl/raw_to_rgb_pkg.sv
// Shared definitions for the Bayer RGGB to RGB rebuild path.
// Holds the row-phase state type, the slot geometry, the RAW slice offset and the rounding average.
package raw_to_rgb_pkg;

  localparam int DEF_BITS_PER_CPNT   = 14;
  localparam int DEF_CPNTS_PER_PIXEL = 3;
  localparam int BIT_NUM             = DEF_BITS_PER_CPNT * DEF_CPNTS_PER_PIXEL;

  // FIRST covers both reset and the first row after a frame start.
  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_EVEN  = 2'd1,
    ST_ODD   = 2'd2
  } row_state_e;

  // Bit offset of the top 8 bits of slot 0 for a given port.
  function automatic int raw8_offset(input int port, input int bits_per_cpnt, input int cpnts);
    return port * bits_per_cpnt * cpnts + bits_per_cpnt - 8;
  endfunction

  // (x + y + 1) >> 1 kept in 9 bits so the carry is not lost.
  function automatic logic [7:0] avg9(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y} + 9'd1;
    return s[8:1];
  endfunction

endpackage

// File: rtl/raw_to_rgb_line_buf.sv
// One-line RAW store: simple dual-port RAM with registered read.
// A read and write to the same address in one cycle returns the old contents.
module raw_to_rgb_line_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/raw_to_rgb.sv
// Rebuilds 8-bit R/G/B from a multi-port RGGB RAW stream with a 2x2 block demosaic.
// Stage 1 aligns current RAW with the previous row from the line buffer; stage 2 is the registered pair mux.
module raw_to_rgb
  import raw_to_rgb_pkg::*;
#(
  parameter int C_PORT_NUM        = 4,
  parameter int C_BITS_PER_CPNT   = DEF_BITS_PER_CPNT,
  parameter int C_CPNTS_PER_PIXEL = DEF_CPNTS_PER_PIXEL,
  parameter int C_MAX_BEATS       = 1024
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  S_VS,
  input  logic                                                  S_HS,
  input  logic                                                  S_DE,
  input  logic [C_BITS_PER_CPNT*C_CPNTS_PER_PIXEL*C_PORT_NUM-1:0] S_VID_DATA,
  input  logic                                                  BYPASS,
  output logic                                                  M_VS,
  output logic                                                  M_HS,
  output logic                                                  M_DE,
  output logic [8*C_PORT_NUM-1:0]                               M_R_Y,
  output logic [8*C_PORT_NUM-1:0]                               M_G_U,
  output logic [8*C_PORT_NUM-1:0]                               M_B_V,
  output logic [1:0]                                            dbg_state
);

  localparam int PIX_W = 8 * C_PORT_NUM;
  localparam int AW    = (C_MAX_BEATS > 1) ? $clog2(C_MAX_BEATS) : 1;
  localparam int CW    = $clog2(C_MAX_BEATS + 1);

  logic [PIX_W-1:0] raw_now;
  logic             data_unused;

  for (genvar i = 0; i < C_PORT_NUM; i++) begin : g_raw
    assign raw_now[8*i +: 8] = S_VID_DATA[raw8_offset(i, C_BITS_PER_CPNT, C_CPNTS_PER_PIXEL) +: 8];
  end
  assign data_unused = ^S_VID_DATA;

  row_state_e       state_q, state_d;
  logic [CW-1:0]    addr_q, addr_d;
  logic             vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;
  logic             vs1_q, vs1_d, hs1_q, hs1_d, de1_q, de1_d;
  logic             byp1_q, byp1_d, first1_q, first1_d, par1_q, par1_d;
  logic [PIX_W-1:0] cur1_q, cur1_d;
  logic             vs2_q, vs2_d, hs2_q, hs2_d, de2_q, de2_d;
  logic [PIX_W-1:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic [PIX_W-1:0] buf_rd;
  logic             vs_rise, de_fall, in_range, buf_en;

  assign vs_rise  = S_VS & ~vs_prev_q;
  assign de_fall  = ~S_DE & de_prev_q;
  assign in_range = addr_q < CW'(C_MAX_BEATS);
  assign buf_en   = S_DE & in_range & ~rst;

  raw_to_rgb_line_buf #(.W(PIX_W), .DEPTH(C_MAX_BEATS), .AW(AW)) u_line_buf (
    .clk   (clk),
    .we    (buf_en),
    .waddr (addr_q[AW-1:0]),
    .wdata (raw_now),
    .re    (buf_en),
    .raddr (addr_q[AW-1:0]),
    .rdata (buf_rd)
  );

  // Frame start outranks a coincident line end.
  always_comb begin
    addr_d    = addr_q;
    state_d   = state_q;
    vs_prev_d = S_VS;
    de_prev_d = S_DE;
    if (vs_rise) begin
      addr_d  = '0;
      state_d = ST_FIRST;
    end else if (S_DE) begin
      if (in_range) addr_d = addr_q + CW'(1);
    end else if (de_fall) begin
      addr_d  = '0;
      state_d = (state_q == ST_ODD) ? ST_EVEN : ST_ODD;
    end
    vs1_d    = S_VS;
    hs1_d    = S_HS;
    de1_d    = S_DE;
    byp1_d   = BYPASS;
    cur1_d   = raw_now;
    first1_d = (state_q == ST_FIRST) | ~in_range;
    par1_d   = (state_q == ST_ODD);
    vs2_d    = vs1_q;
    hs2_d    = hs1_q;
    de2_d    = de1_q;
  end

  always_comb begin
    logic [7:0] c0, c1, b0, b1, pr, pg, pb;
    r2_d = '0;
    g2_d = '0;
    b2_d = '0;
    c0 = '0; c1 = '0; b0 = '0; b1 = '0; pr = '0; pg = '0; pb = '0;
    if (de1_q && byp1_q) begin
      r2_d = cur1_q;
      g2_d = cur1_q;
      b2_d = cur1_q;
    end else if (de1_q) begin
      for (int m = 0; m < C_PORT_NUM / 2; m++) begin
        c0 = cur1_q[16*m +: 8];
        c1 = cur1_q[16*m+8 +: 8];
        b0 = buf_rd[16*m +: 8];
        b1 = buf_rd[16*m+8 +: 8];
        if (first1_q && !par1_q) begin
          pr = c0;  pg = c1;  pb = 8'h00;
        end else if (first1_q) begin
          pr = 8'h00;  pg = c0;  pb = c1;
        end else if (!par1_q) begin
          pr = c0;  pg = avg9(c1, b0);  pb = b1;
        end else begin
          pr = b0;  pg = avg9(c0, b1);  pb = c1;
        end
        r2_d[16*m +: 16] = {pr, pr};
        g2_d[16*m +: 16] = {pg, pg};
        b2_d[16*m +: 16] = {pb, pb};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FIRST;
      addr_q    <= '0;
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
      vs1_q     <= 1'b0;
      hs1_q     <= 1'b0;
      de1_q     <= 1'b0;
      byp1_q    <= 1'b0;
      first1_q  <= 1'b1;
      par1_q    <= 1'b0;
      cur1_q    <= '0;
      vs2_q     <= 1'b0;
      hs2_q     <= 1'b0;
      de2_q     <= 1'b0;
      r2_q      <= '0;
      g2_q      <= '0;
      b2_q      <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      vs_prev_q <= vs_prev_d;
      de_prev_q <= de_prev_d;
      vs1_q     <= vs1_d;
      hs1_q     <= hs1_d;
      de1_q     <= de1_d;
      byp1_q    <= byp1_d;
      first1_q  <= first1_d;
      par1_q    <= par1_d;
      cur1_q    <= cur1_d;
      vs2_q     <= vs2_d;
      hs2_q     <= hs2_d;
      de2_q     <= de2_d;
      r2_q      <= r2_d;
      g2_q      <= g2_d;
      b2_q      <= b2_d;
    end
  end

  assign M_VS      = vs2_q;
  assign M_HS      = hs2_q;
  assign M_DE      = de2_q;
  assign M_R_Y     = r2_q;
  assign M_G_U     = g2_q;
  assign M_B_V     = b2_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_raw_to_rgb.sv
// Bench for raw_to_rgb: directed Bayer rows, a row-level behavioural model with a 2-deep expected queue,
// per-cycle output comparison and a set of hand-computed literal checks.
module tb_raw_to_rgb;

  localparam int NP   = 4;
  localparam int BPC  = 14;
  localparam int CPP  = 3;
  localparam int MAXB = 1024;
  localparam int SLOT = BPC * CPP;
  localparam int DW   = SLOT * NP;
  localparam int OW   = 8 * NP;
  localparam int EW   = 3 + 3 * OW;

  logic          clk = 1'b0;
  logic          rst, s_vs, s_hs, s_de, bypass;
  logic [DW-1:0] s_data;
  logic          m_vs, m_hs, m_de;
  logic [OW-1:0] m_r, m_g, m_b;
  logic [1:0]    dbg_state;

  raw_to_rgb #(
    .C_PORT_NUM(NP), .C_BITS_PER_CPNT(BPC), .C_CPNTS_PER_PIXEL(CPP), .C_MAX_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst(rst), .S_VS(s_vs), .S_HS(s_hs), .S_DE(s_de), .S_VID_DATA(s_data),
    .BYPASS(bypass), .M_VS(m_vs), .M_HS(m_hs), .M_DE(m_de),
    .M_R_Y(m_r), .M_G_U(m_g), .M_B_V(m_b), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          cmp_en   = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_cur;
  logic [23:0]   log_q[$];

  task automatic check_val(input string name, input logic [EW-1:0] act, input logic [EW-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic check_log(input string name, input int idx, input logic [23:0] expv);
    logic [23:0] act;
    act = (idx < log_q.size()) ? log_q[idx] : 24'hxxxxxx;
    check_val(name, EW'(act), EW'(expv));
  endtask

  function automatic logic [7:0] raw_of(input logic [DW-1:0] d, input int p);
    logic [BPC-1:0] s;
    s = d[p*SLOT +: BPC];
    return 8'(s >> (BPC - 8));
  endfunction

  // Model: rows counted since frame start / reset; previous row kept per beat.
  int   mem_m[0:15][0:NP-1];
  int   row_idx, beat;
  logic prev_de, prev_vs;

  initial begin
    exp_q.push_back('0);
    exp_cur = '0;
    row_idx = 0; beat = 0; prev_de = 1'b0; prev_vs = 1'b0;
    forever begin
      logic [OW-1:0] er, eg, eb;
      int raw [NP];
      int c0, c1, b0, b1, vr, vg, vb;
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        exp_q.push_back('0);
        exp_cur = '0;
        row_idx = 0; beat = 0; prev_de = 1'b0; prev_vs = 1'b0;
      end else begin
        er = '0; eg = '0; eb = '0;
        if (s_de) begin
          for (int i = 0; i < NP; i++) raw[i] = int'(raw_of(s_data, i));
          for (int m = 0; m < NP / 2; m++) begin
            c0 = raw[2*m]; c1 = raw[2*m+1];
            b0 = mem_m[beat][2*m]; b1 = mem_m[beat][2*m+1];
            if (row_idx == 0)          begin vr = c0; vg = c1;                vb = 0;  end
            else if (row_idx % 2 == 0) begin vr = c0; vg = (c1 + b0 + 1) / 2; vb = b1; end
            else                       begin vr = b0; vg = (c0 + b1 + 1) / 2; vb = c1; end
            for (int k = 0; k < 2; k++) begin
              er[8*(2*m+k) +: 8] = 8'(vr);
              eg[8*(2*m+k) +: 8] = 8'(vg);
              eb[8*(2*m+k) +: 8] = 8'(vb);
            end
          end
          if (bypass)
            for (int i = 0; i < NP; i++) begin
              er[8*i +: 8] = 8'(raw[i]);
              eg[8*i +: 8] = 8'(raw[i]);
              eb[8*i +: 8] = 8'(raw[i]);
            end
          if (beat < 16) for (int i = 0; i < NP; i++) mem_m[beat][i] = raw[i];
          beat++;
        end
        exp_q.push_back({s_vs, s_hs, s_de, er, eg, eb});
        exp_cur = exp_q.pop_front();
        if (s_vs && !prev_vs) begin
          row_idx = 0; beat = 0;
        end else if (!s_de && prev_de) begin
          row_idx++; beat = 0;
        end
        prev_de = s_de;
        prev_vs = s_vs;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check_val("cycle", {m_vs, m_hs, m_de, m_r, m_g, m_b}, exp_cur);
        if (m_de === 1'b1) log_q.push_back({m_r[7:0], m_g[7:0], m_b[7:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic vs, input logic hs, input logic de, input logic [DW-1:0] d);
    @(negedge clk);
    s_vs = vs; s_hs = hs; s_de = de; s_data = d;
  endtask

  function automatic logic [DW-1:0] mk_pix(input logic [7:0] p0, input logic [7:0] p1,
                                           input logic [7:0] p2, input logic [7:0] p3);
    logic [DW-1:0] d;
    logic [7:0]    p [NP];
    p = '{p0, p1, p2, p3};
    d = '0;
    for (int i = 0; i < NP; i++) begin
      d[i*SLOT +: BPC] = {p[i], 6'($urandom_range(0, 63))};
      d[i*SLOT + BPC +: SLOT - BPC] = (SLOT - BPC)'($urandom);
    end
    return d;
  endfunction

  task automatic vs_pulse();
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Two-beat line of pattern a b a b; vs_end raises VS on the DE falling cycle.
  task automatic send_row(input logic [7:0] a, input logic [7:0] b, input logic vs_end);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b1, mk_pix(a, b, a, b));
    tick(1'b0, 1'b0, 1'b1, mk_pix(a, b, a, b));
    tick(vs_end, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic send_row_rand();
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 2; k++)
      tick(1'b0, 1'b0, 1'b1, mk_pix(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)));
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    rst = 1'b1; s_vs = 1'b0; s_hs = 1'b0; s_de = 1'b0; s_data = '0; bypass = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", {m_vs, m_hs, m_de, m_r, m_g, m_b}, '0);
    check_val("reset_state", EW'(dbg_state), EW'(2'd0));
    rst = 1'b0;
    cmp_en = 1'b1;

    // Frame A: flat field
    vs_pulse();
    for (int r = 0; r < 4; r++) begin
      if (r % 2 == 0) send_row(8'h40, 8'h80, 1'b0);
      else            send_row(8'h80, 8'hC0, 1'b0);
    end

    // Frame B: green mismatch, then VS coinciding with DE fall after 3 rows
    vs_pulse();
    send_row(8'h40, 8'h80, 1'b0);
    send_row(8'h81, 8'hC0, 1'b0);
    send_row(8'h40, 8'h80, 1'b1);
    send_row(8'h81, 8'hC0, 1'b0);
    send_row(8'h40, 8'h80, 1'b0);

    // Frame C: random rows
    vs_pulse();
    repeat (4) send_row_rand();

    // Frame D: reset during row 2
    vs_pulse();
    send_row(8'h40, 8'h80, 1'b0);
    send_row(8'h80, 8'hC0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b1, mk_pix(8'h40, 8'h80, 8'h40, 8'h80));
    tick(1'b0, 1'b0, 1'b1, mk_pix(8'h40, 8'h80, 8'h40, 8'h80));
    tick(1'b0, 1'b0, 1'b0, '0);
    check_val("pre_rst_de", EW'(m_de), EW'(1'b1));
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, '0);
    check_val("rst_out_zero", {m_vs, m_hs, m_de, m_r, m_g, m_b}, '0);
    check_val("rst_state", EW'(dbg_state), EW'(2'd0));
    tick(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    tick(1'b0, 1'b0, 1'b0, '0);
    send_row(8'h40, 8'h80, 1'b0);
    send_row(8'h80, 8'hC0, 1'b0);

    // Bypass with a single beat: latency and timing mirror
    bypass = 1'b1;
    d = '0;
    d[0 +: BPC]          = 14'h2A5C;
    d[BPC +: SLOT - BPC] = 28'h5A5A5A5;
    d[SLOT +: BPC]       = 14'h3FFF;
    d[2*SLOT +: BPC]     = 14'h0040;
    d[3*SLOT +: BPC]     = 14'h1F80;
    tick(1'b1, 1'b1, 1'b1, d);
    tick(1'b0, 1'b0, 1'b0, '0);
    check_val("lat_plus1_de", EW'({m_vs, m_hs, m_de}), EW'(3'b000));
    tick(1'b0, 1'b0, 1'b0, '0);
    check_val("lat_plus2_timing", EW'({m_vs, m_hs, m_de}), EW'(3'b111));
    check_val("bypass_r", EW'(m_r), EW'(32'h7E01FFA9));
    check_val("bypass_g", EW'(m_g), EW'(32'h7E01FFA9));
    check_val("bypass_b", EW'(m_b), EW'(32'h7E01FFA9));
    tick(1'b0, 1'b0, 1'b0, '0);
    check_val("lat_plus3_de", EW'(m_de), EW'(1'b0));
    bypass = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b0, '0);

    // Literal pins on port 0 of logged output beats
    check_log("flat_row0", 0, 24'h408000);
    check_log("flat_row1", 2, 24'h4080C0);
    check_log("flat_row2", 5, 24'h4080C0);
    check_log("flat_row3", 7, 24'h4080C0);
    check_log("gm_row0", 8, 24'h408000);
    check_log("gm_row1", 10, 24'h4081C0);
    check_log("gm_row2", 12, 24'h4081C0);
    check_log("vs_mid_first", 14, 24'h81C000);
    check_log("vs_mid_par1", 16, 24'h818080);
    check_log("rst_row2_beat0", 30, 24'h4080C0);
    check_log("rst_next_first", 31, 24'h408000);
    check_log("rst_next_par1", 33, 24'h4080C0);
    check_log("bypass_log", 35, 24'hA9A9A9);
    check_val("log_count", EW'(log_q.size()), EW'(36));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
